// File: rtl/prism_cfg_loader.sv
// rtl/prism_cfg_loader.sv - PRISM configuration loader: staging, shift/direct/clear commit, readback
//
// Collects 32-bit bus writes into a WIDTH-bit staging word and commits it
// into a DEPTH-entry flip-flop configuration store that drives cfg_bus.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   address       register byte offset
//   data_in       write data
//   data_write_n  2'b10 = 32-bit write, anything else = no write
//   data_out      combinational read data for address
//   cfg_bus       entry i at bits [(i+1)*WIDTH-1 -: WIDTH]
//   cfg_stable    high when no SHIFT/CLEAR sequence is running
//   irq           sticky completion flag
module prism_cfg_loader #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             address,
  input  logic [31:0]            data_in,
  input  logic [1:0]             data_write_n,
  output logic [31:0]            data_out,
  output logic [WIDTH*DEPTH-1:0] cfg_bus,
  output logic                   cfg_stable,
  output logic                   irq
);

  localparam int L  = WIDTH / 32;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     cnt_q;
  logic [IW-1:0]     rdidx_q;
  logic [31:0]       stage_q [L];
  logic [WIDTH-1:0]  entry_q [DEPTH];
  logic [WIDTH-1:0]  staging;
  logic              done_q, err_q;
  logic [7:0]        load_count_q;

  logic        wr_en, busy, lane_ok;
  logic        stage_sel, rd_sel, ctrl_sel, rdidx_sel;
  logic        ctrl_wr, cmd_ok, reject;
  logic        do_shift, do_direct, do_clear, idx_ok, rdidx_ok, seq_last;
  logic [1:0]  lane;
  logic [2:0]  cmd;
  logic [3:0]  idx;
  logic        unused_bits;

  assign unused_bits = ^{data_in[30:12], data_in[7:3]};

  // Address decode; lanes beyond L alias to nothing.
  assign wr_en     = (data_write_n == 2'b10);
  assign lane      = address[3:2];
  assign lane_ok   = ({30'b0, lane} < 32'(L));
  assign stage_sel = (address[5:4] == 2'b00) && (address[1:0] == 2'b00) && lane_ok;
  assign rd_sel    = (address[5:4] == 2'b10) && (address[1:0] == 2'b00) && lane_ok;
  assign ctrl_sel  = (address == 6'h10);
  assign rdidx_sel = (address == 6'h14);

  assign cmd       = data_in[2:0];
  assign idx       = data_in[11:8];
  assign busy      = (state_q != ST_IDLE);
  assign ctrl_wr   = wr_en && ctrl_sel;
  assign cmd_ok    = ctrl_wr && !busy;
  assign do_shift  = cmd_ok && (cmd == 3'd1);
  assign do_direct = cmd_ok && (cmd == 3'd2);
  assign do_clear  = cmd_ok && (cmd == 3'd3);
  assign idx_ok    = ({1'b0, idx} < 5'(DEPTH));
  assign rdidx_ok  = ({{(32-IW){1'b0}}, rdidx_q} < 32'(DEPTH));
  assign seq_last  = busy && (cnt_q == '0);

  // Staging and command writes are refused (and flagged) mid-sequence so
  // the commit always uses the staging word that was present at acceptance.
  assign reject = busy && wr_en && (stage_sel || (ctrl_sel && cmd != 3'd0));

  assign cfg_stable = !busy;
  assign irq        = done_q;

  always_comb begin
    staging = '0;
    for (int k = 0; k < L; k++) staging[k*32 +: 32] = stage_q[k];
  end

  always_comb begin
    cfg_bus = '0;
    for (int i = 0; i < DEPTH; i++) cfg_bus[i*WIDTH +: WIDTH] = entry_q[i];
  end

  always_comb begin
    data_out = '0;
    if (stage_sel) begin
      for (int k = 0; k < L; k++)
        if ({30'b0, lane} == 32'(k)) data_out = stage_q[k];
    end else if (ctrl_sel) begin
      data_out = {8'h00, 8'(DEPTH), load_count_q, 5'b0, err_q, done_q, busy};
    end else if (rdidx_sel) begin
      data_out = {{(32-IW){1'b0}}, rdidx_q};
    end else if (rd_sel && rdidx_ok) begin
      for (int k = 0; k < L; k++)
        if ({30'b0, lane} == 32'(k)) data_out = entry_q[rdidx_q][k*32 +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (do_shift)      state_d = ST_SHIFT;
        else if (do_clear) state_d = ST_CLEAR;
      end
      ST_SHIFT, ST_CLEAR: begin
        if (cnt_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      rdidx_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      load_count_q <= '0;
      for (int k = 0; k < L; k++)     stage_q[k] <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      if (wr_en && stage_sel && !busy)
        for (int k = 0; k < L; k++)
          if ({30'b0, lane} == 32'(k)) stage_q[k] <= data_in;

      if (wr_en && rdidx_sel) rdidx_q <= data_in[IW-1:0];

      // Flag clear comes first so any set in the same cycle overrides it.
      if (ctrl_wr && data_in[31]) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (reject) err_q <= 1'b1;
      if (do_direct) begin
        if (idx_ok) done_q <= 1'b1;
        else        err_q  <= 1'b1;
      end

      if (do_shift || do_clear) cnt_q <= IW'(DEPTH - 1);
      else if (busy)            cnt_q <= cnt_q - 1'b1;

      if (seq_last) begin
        done_q <= 1'b1;
        if (state_q == ST_SHIFT) begin
          if (load_count_q != 8'hFF) load_count_q <= load_count_q + 8'd1;
        end else begin
          load_count_q <= '0;
        end
      end

      // Shift runs tail first so each entry copies its neighbour before
      // that neighbour is overwritten.
      if (state_q == ST_SHIFT && cnt_q == '0) entry_q[0] <= staging;
      for (int i = 1; i < DEPTH; i++)
        if (state_q == ST_SHIFT && cnt_q == IW'(i)) entry_q[i] <= entry_q[i-1];

      for (int i = 0; i < DEPTH; i++) begin
        if (state_q == ST_CLEAR && cnt_q == IW'(i)) entry_q[i] <= '0;
        if (do_direct && idx_ok && ({1'b0, idx} == 5'(i))) entry_q[i] <= staging;
      end
    end
  end

endmodule

// File: tb/tb_prism_cfg_loader.sv
// tb/tb_prism_cfg_loader.sv - scoreboard bench for prism_cfg_loader
module tb_prism_cfg_loader;

  localparam int WIDTH = 64;
  localparam int DEPTH = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [5:0]             address;
  logic [31:0]            data_in;
  logic [1:0]             data_write_n;
  logic [31:0]            data_out;
  logic [WIDTH*DEPTH-1:0] cfg_bus;
  logic                   cfg_stable;
  logic                   irq;

  prism_cfg_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_out(data_out), .cfg_bus(cfg_bus),
    .cfg_stable(cfg_stable), .irq(irq)
  );

  always #5 clk = ~clk;

  // kind 0: data_out, kind 1: cfg_bus entry idx, kind 2: {irq, cfg_stable}
  typedef struct {
    int          kind;
    int          idx;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  logic chk_req = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [63:0] act;
    if (chk_req) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: no expected value queued");
      end else begin
        e = sb.pop_front();
        case (e.kind)
          0:       act = {32'b0, data_out};
          1:       act = cfg_bus[e.idx*WIDTH +: WIDTH];
          default: act = {62'b0, irq, cfg_stable};
        endcase
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input int kind, input int idx, input logic [63:0] exp, input string name);
    exp_t e;
    e.kind = kind; e.idx = idx; e.exp = exp; e.name = name;
    sb.push_back(e);
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string name);
    address = a;
    expect_val(0, 0, {32'b0, exp}, name);
  endtask

  task automatic ent(input int i, input logic [63:0] exp, input string name);
    expect_val(1, i, exp, name);
  endtask

  task automatic pins(input logic [1:0] exp, input string name);
    expect_val(2, 0, {62'b0, exp}, name);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    address = a; data_in = d; data_write_n = 2'b10;
    @(posedge clk);
    #1 data_write_n = 2'b11;
  endtask

  task automatic busy_run(input logic [31:0] exp_busy, input string name);
    repeat (DEPTH) begin
      rd(6'h10, exp_busy, name);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; address = '0; data_in = '0; data_write_n = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    rd(6'h10, 32'h0008_0000, "reset_status");
    ent(0, 64'h0, "reset_entry0");
    ent(7, 64'h0, "reset_entry7");
    pins(2'b01, "reset_irq_stable");

    // Two shifts
    wr(6'h00, 32'h1111_1111);
    wr(6'h04, 32'h2222_2222);
    rd(6'h04, 32'h2222_2222, "stage1_readback");
    wr(6'h10, 32'h0000_0001);
    busy_run(32'h0008_0001, "shift1_busy");
    rd(6'h10, 32'h0008_0102, "shift1_done");
    pins(2'b11, "shift1_irq");
    ent(0, 64'h2222_2222_1111_1111, "shift1_entry0");

    wr(6'h00, 32'h3333_3333);
    wr(6'h04, 32'h4444_4444);
    wr(6'h10, 32'h0000_0001);
    busy_run(32'h0008_0103, "shift2_busy");
    rd(6'h10, 32'h0008_0202, "shift2_done");
    ent(0, 64'h4444_4444_3333_3333, "shift2_entry0");
    ent(1, 64'h2222_2222_1111_1111, "shift2_entry1");
    wr(6'h14, 32'h0000_0001);
    rd(6'h14, 32'h0000_0001, "rdidx_readback");
    rd(6'h24, 32'h2222_2222, "rddata1_entry1");
    rd(6'h20, 32'h1111_1111, "rddata0_entry1");

    // Direct write, then out-of-range index
    wr(6'h10, 32'h8000_0000);
    rd(6'h10, 32'h0008_0200, "flag_clear");
    wr(6'h00, 32'hCAFE_F00D);
    wr(6'h04, 32'hDEAD_BEEF);
    wr(6'h10, 32'h0000_0502);
    rd(6'h10, 32'h0008_0202, "direct_done");
    ent(5, 64'hDEAD_BEEF_CAFE_F00D, "direct_entry5");
    ent(0, 64'h4444_4444_3333_3333, "direct_entry0_kept");
    ent(4, 64'h0, "direct_entry4_kept");
    wr(6'h10, 32'h0000_0902);
    rd(6'h10, 32'h0008_0206, "direct_idx9_err");
    ent(5, 64'hDEAD_BEEF_CAFE_F00D, "idx9_entry5_kept");
    ent(1, 64'h2222_2222_1111_1111, "idx9_entry1_kept");

    // Writes refused during a shift
    wr(6'h10, 32'h8000_0000);
    wr(6'h10, 32'h0000_0001);
    wr(6'h00, 32'hFFFF_FFFF);
    wr(6'h10, 32'h0000_0003);
    rd(6'h10, 32'h0008_0205, "busy_reject_err");
    repeat (DEPTH - 2) @(posedge clk);
    #1;
    rd(6'h10, 32'h0008_0306, "shift3_done");
    ent(0, 64'hDEAD_BEEF_CAFE_F00D, "shift3_entry0");
    ent(2, 64'h2222_2222_1111_1111, "shift3_entry2");
    ent(5, 64'h0, "shift3_entry5");
    ent(6, 64'hDEAD_BEEF_CAFE_F00D, "shift3_entry6");
    rd(6'h00, 32'hCAFE_F00D, "stage0_unchanged");

    // Flag clear drops irq, then clear sequence
    wr(6'h10, 32'h8000_0000);
    pins(2'b01, "irq_cleared");
    rd(6'h10, 32'h0008_0300, "clear_flags_status");
    wr(6'h10, 32'h0000_0003);
    busy_run(32'h0008_0301, "clear_busy");
    rd(6'h10, 32'h0008_0002, "clear_done");
    ent(0, 64'h0, "clear_entry0");
    ent(6, 64'h0, "clear_entry6");

    // Reset in the middle of a shift
    wr(6'h10, 32'h0000_0002);
    wr(6'h10, 32'h0000_0702);
    ent(7, 64'hDEAD_BEEF_CAFE_F00D, "direct_entry7");
    wr(6'h10, 32'h0000_0001);
    @(posedge clk);
    #1;
    rd(6'h10, 32'h0008_0003, "mid_shift_busy");
    rst_n = 1'b0;
    rd(6'h10, 32'h0008_0000, "abort_status");
    ent(0, 64'h0, "abort_entry0");
    ent(6, 64'h0, "abort_entry6");
    pins(2'b01, "abort_pins");
    @(posedge clk);
    #1 rst_n = 1'b1;
    wr(6'h14, 32'h0000_0007);
    rd(6'h14, 32'h0000_0007, "rdidx7");
    rd(6'h24, 32'h0000_0000, "rddata1_idx7");
    wr(6'h08, 32'h5555_5555);
    rd(6'h08, 32'h0000_0000, "lane2_undecoded");
    rd(6'h30, 32'h0000_0000, "undecoded_0x30");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prism_cfg_loader.md
# prism_cfg_loader

Parametrised successor to the PRISM configuration loader: accepts 32-bit TinyQV bus writes, assembles them into WIDTH-bit staging words, and commits them into a DEPTH-entry configuration store. Supports shift-in, direct-indexed write and clear modes, plus per-entry readback. Raises a completion interrupt. Sits between the peripheral register decode and the PRISM engine's `cfg_bus`; storage is flip-flop based so every entry is observable.

## Interface
- `WIDTH`, 64: config word width; multiple of 32, range 32..128. L = WIDTH/32 lanes.
- `DEPTH`, 8: number of config entries, range 2..16. IW = clog2(DEPTH), internal.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `address`  in  6  register offset.
- `data_in`  in  32  write data.
- `data_write_n`  in  2  11 = none, 10 = 32-bit write. 00 and 01 are ignored entirely.
- `data_out`  out  32  combinational read data for `address`.
- `cfg_bus`  out  WIDTH*DEPTH  entry i at bits [(i+1)*WIDTH-1 -: WIDTH].
- `cfg_stable`  out  1  equals !busy.
- `irq`  out  1  equals the sticky `done` flag.

## Operation
Register map. Undecoded offsets and out-of-range lanes read 0; writes to them are ignored.
- 0x00+4k (k<L) STAGE[k]: write loads staging lane k; read returns it.
- 0x10 CTRL (write):
  - bits[2:0] cmd: 0 nop, 1 SHIFT, 2 DIRECT, 3 CLEAR, others nop.
  - bits[11:8] idx.
  - bit31 clears `done` and `err`.
- 0x10 STATUS (read): bit0 busy, bit1 done, bit2 err, [15:8] load_count, [23:16] DEPTH.
- 0x14 RDIDX: write bits[IW-1:0]. Read returns the value zero-extended.
- 0x20+4k RDDATA[k]: lane k of entry RDIDX. Reads 0 if RDIDX ≥ DEPTH.

FSM states: IDLE, SHIFT, CLEAR.
- SHIFT: down-counter c runs DEPTH-1..0, one stage per cycle, tail first.
  - For c>0: entry[c] ← entry[c-1].
  - For c=0: entry[0] ← staging.
  - Then load_count += 1 (saturates at 255), done ← 1, return to IDLE.
- DIRECT: completes in the acceptance cycle; the FSM stays in IDLE.
  - entry[idx] ← staging, done ← 1.
  - idx ≥ DEPTH: no write, err ← 1, done unchanged.
- CLEAR: counter runs DEPTH-1..0 zeroing entry[c]. At the end done ← 1; load_count ← 0.
- busy = state ≠ IDLE.
- While busy, any STAGE or CTRL cmd≠0 write is ignored and sets err.
  - CTRL bit31 is always honoured, even while busy.
  - RDIDX writes and all reads are always allowed.
- Same write with bit31 and cmd≠0: flags clear first. The command may set them again in a later cycle; the DIRECT err/done update wins in the same cycle.

## Timing
- Reset values: all entries 0, staging 0, RDIDX 0, state IDLE, load_count 0. Outputs at reset: `done`/`err` 0, `cfg_bus` 0, `cfg_stable` 1, `irq` 0.
- Asserting reset mid-SHIFT or mid-CLEAR aborts the operation and applies the reset values immediately; no partial commit survives.
- Reads have zero wait states. `data_out` is combinational from the current register state; the peripheral ties data_ready to 1.
- Write accepted at edge T:
  - STAGE and RDIDX are visible at T+1.
  - DIRECT: entry visible on `cfg_bus` at T+1, with done=1.
- SHIFT or CLEAR accepted at T:
  - busy=1 during cycles T+1..T+DEPTH.
  - entry[DEPTH-1] updates at edge T+1; entry[0] updates at edge T+DEPTH.
  - busy=0, done=1, `irq`=1 from T+DEPTH, after that edge.
- Back-to-back: a command at edge T+DEPTH, the first idle edge, is accepted.

## Test plan
- Reset → STATUS = 0x00DEPTH_00_0 (DEPTH=8 gives 0x00080000), `cfg_bus` = 0, `cfg_stable` = 1.
- STAGE[0]=0x11111111, STAGE[1]=0x22222222, CTRL=1; repeat with 0x33333333/0x44444444 → entry0 = 0x4444444433333333, entry1 = 0x2222222211111111, load_count = 2, busy high exactly 8 cycles per shift.
- STAGE = 0xDEADBEEF_CAFEF00D, CTRL=0x00000502 → entry5 = that value, the other entries unchanged, done=1 at T+1. Then CTRL idx=9 with cmd 2 → err=1, no entry changes.
- During a SHIFT, write STAGE[0]=0xFFFFFFFF and CTRL=3 → both ignored, err=1. The shift completes with the original staging value.
- CTRL=0x80000000 while done=1 and err=1 → `irq` falls at T+1. CTRL=3 → all entries 0, load_count = 0 after 8 busy cycles.
- Assert rst_n low at cycle 3 of a SHIFT → all entries 0, busy=0 immediately. RDIDX=7 with RDDATA[1] read returns 0.
